seg7_text_writer: RTL and testbench

SEG7_TEXT_WRITER -- requirements
Module: seg7_text_writer

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_text_writer.sv | 113 +++++++++++
 tb/tb_seg7_text_writer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg: shared FSM state type and ASCII control codes for the 7-seg text path.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t CLEAR = 1'b1;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_FF = 8'h0C;

  // Everything except the C0 control range and DEL is displayed as-is.
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c != 8'h7F);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_text_writer.sv
// ---------------------------------------------------------------------------
// seg7_text_writer: turns a valid/ready character stream into an 8-digit ASCII buffer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_text_writer
  import seg7_pkg::*;
#(
  parameter logic [7:0] BLANK_CHAR = 8'h00
) (
  input  logic        CLK100MHZ,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  input  logic        mode,
  output logic [63:0] asciix8,
  output logic [2:0]  cursor,
  output logic        wrap
);

  state_t      state_q, state_d;
  logic [63:0] buf_q, buf_d;
  logic [2:0]  cursor_q, cursor_d;
  logic [2:0]  clr_cnt_q, clr_cnt_d;
  logic        wrap_q, wrap_d;
  logic        fire;

  assign in_ready = (state_q == IDLE);
  assign fire     = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cursor_d  = cursor_q;
    clr_cnt_d = clr_cnt_q;
    wrap_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (fire) begin
          if (is_printable(in_char)) begin
            if (!mode) begin
              buf_d[8*cursor_q +: 8] = in_char;
              if (cursor_q == 3'd0) begin
                cursor_d = 3'd7;
                wrap_d   = 1'b1;
              end else begin
                cursor_d = cursor_q - 3'd1;
              end
            end else begin
              buf_d = {buf_q[55:0], in_char};
            end
          end else begin
            case (in_char)
              ASCII_CR: cursor_d = 3'd7;
              ASCII_BS: begin
                if (!mode) begin
                  // Step back toward digit 7 (saturating) and blank the new position.
                  if (cursor_q != 3'd7) begin
                    cursor_d = cursor_q + 3'd1;
                  end
                  buf_d[8*cursor_d +: 8] = BLANK_CHAR;
                end else begin
                  buf_d = {BLANK_CHAR, buf_q[63:8]};
                end
              end
              ASCII_FF: begin
                state_d   = CLEAR;
                clr_cnt_d = 3'd0;
              end
              default: ;
            endcase
          end
        end
      end

      CLEAR: begin
        buf_d[8*clr_cnt_q +: 8] = BLANK_CHAR;
        clr_cnt_d               = clr_cnt_q + 3'd1;
        if (clr_cnt_q == 3'd7) begin
          cursor_d = 3'd7;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!resetn) begin
      state_q   <= IDLE;
      buf_q     <= 64'h0;
      cursor_q  <= 3'd7;
      clr_cnt_q <= 3'd0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cursor_q  <= cursor_d;
      clr_cnt_q <= clr_cnt_d;
      wrap_q    <= wrap_d;
    end
  end

  assign asciix8 = buf_q;
  assign cursor  = cursor_q;
  assign wrap    = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_text_writer.sv
// ---------------------------------------------------------------------------
// tb_seg7_text_writer: directed scoreboard bench for seg7_text_writer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seg7_text_writer;

  logic        CLK100MHZ = 1'b0;
  logic        resetn    = 1'b0;
  logic        in_valid  = 1'b0;
  logic [7:0]  in_char   = 8'h00;
  logic        mode      = 1'b0;
  logic        in_ready;
  logic [63:0] asciix8;
  logic [2:0]  cursor;
  logic        wrap;

  always #5 CLK100MHZ = ~CLK100MHZ;

  seg7_text_writer #(.BLANK_CHAR(8'h00)) dut (
    .CLK100MHZ (CLK100MHZ),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .mode      (mode),
    .asciix8   (asciix8),
    .cursor    (cursor),
    .wrap      (wrap)
  );

  typedef struct {
    logic [63:0] buf_v;
    logic [2:0]  cur;
    logic        wrp;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: one expected entry is consumed the cycle after every accepted transfer.
  logic  fire_q = 1'b0;
  logic  mon_en = 1'b0;
  exp_t  mon_e;
  string mon_nm;

  always @(posedge CLK100MHZ) fire_q <= in_valid && in_ready && resetn;

  always @(negedge CLK100MHZ) begin
    if (mon_en) begin
      if (fire_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow actual=transfer required=none");
        end else begin
          mon_e  = exp_q.pop_front();
          mon_nm = name_q.pop_front();
          check({mon_nm, "_buf"}, asciix8, mon_e.buf_v);
          check({mon_nm, "_cursor"}, {61'd0, cursor}, {61'd0, mon_e.cur});
          check({mon_nm, "_wrap"}, {63'd0, wrap}, {63'd0, mon_e.wrp});
        end
      end else begin
        check("wrap_idle", {63'd0, wrap}, 64'd0);
      end
    end
  end

  task automatic send(input logic [7:0] ch, input logic md, input logic [63:0] eb,
                      input logic [2:0] ec, input logic ew, input string nm);
    int g;
    in_valid = 1'b1;
    in_char  = ch;
    mode     = md;
    exp_q.push_back('{eb, ec, ew});
    name_q.push_back(nm);
    check({nm, "_ready"}, {63'd0, in_ready}, 64'd1);
    g = 0;
    while (!in_ready && g < 40) begin
      @(negedge CLK100MHZ);
      g++;
    end
    if (g >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=in_ready_low required=accept", nm);
    end
    @(negedge CLK100MHZ);
    in_valid = 1'b0;
  endtask

  initial begin
    int cnt;

    // Reset values
    repeat (3) @(negedge CLK100MHZ);
    check("rst_buf", asciix8, 64'h0);
    check("rst_cursor", {61'd0, cursor}, 64'd7);
    check("rst_wrap", {63'd0, wrap}, 64'd0);
    resetn = 1'b1;
    @(negedge CLK100MHZ);
    check("rst_ready", {63'd0, in_ready}, 64'd1);
    mon_en = 1'b1;

    // Mode 0 cursor writes, back-to-back
    send("A", 1'b0, 64'h4100_0000_0000_0000, 3'd6, 1'b0, "wr_A");
    send("B", 1'b0, 64'h4142_0000_0000_0000, 3'd5, 1'b0, "wr_B");
    send("C", 1'b0, 64'h4142_4300_0000_0000, 3'd4, 1'b0, "wr_C");

    // Mode changes without a transfer leave state untouched
    mode = 1'b1;
    repeat (2) @(negedge CLK100MHZ);
    mode = 1'b0;
    @(negedge CLK100MHZ);
    check("mode_idle_buf", asciix8, 64'h4142_4300_0000_0000);
    check("mode_idle_cursor", {61'd0, cursor}, 64'd4);

    send(8'h0D, 1'b0, 64'h4142_4300_0000_0000, 3'd7, 1'b0, "cr0");

    // Nine characters: wrap after the eighth
    send("1", 1'b0, 64'h3142_4300_0000_0000, 3'd6, 1'b0, "d1");
    send("2", 1'b0, 64'h3132_4300_0000_0000, 3'd5, 1'b0, "d2");
    send("3", 1'b0, 64'h3132_3300_0000_0000, 3'd4, 1'b0, "d3");
    send("4", 1'b0, 64'h3132_3334_0000_0000, 3'd3, 1'b0, "d4");
    send("5", 1'b0, 64'h3132_3334_3500_0000, 3'd2, 1'b0, "d5");
    send("6", 1'b0, 64'h3132_3334_3536_0000, 3'd1, 1'b0, "d6");
    send("7", 1'b0, 64'h3132_3334_3536_3700, 3'd0, 1'b0, "d7");
    send("8", 1'b0, 64'h3132_3334_3536_3738, 3'd7, 1'b1, "d8");
    send("9", 1'b0, 64'h3932_3334_3536_3738, 3'd6, 1'b0, "d9");

    // Backspace, ignored codes, CR, backspace at position 7
    send(8'h08, 1'b0, 64'h0032_3334_3536_3738, 3'd7, 1'b0, "bs0_c6");
    send(8'h01, 1'b0, 64'h0032_3334_3536_3738, 3'd7, 1'b0, "ign01");
    send(8'h7F, 1'b1, 64'h0032_3334_3536_3738, 3'd7, 1'b0, "ign7f");
    send("X",   1'b0, 64'h5832_3334_3536_3738, 3'd6, 1'b0, "wr_X1");
    send(8'h0D, 1'b0, 64'h5832_3334_3536_3738, 3'd7, 1'b0, "cr1");
    send(8'h08, 1'b0, 64'h0032_3334_3536_3738, 3'd7, 1'b0, "bs0_c7");
    send("X",   1'b0, 64'h5832_3334_3536_3738, 3'd6, 1'b0, "wr_X2");

    // Form feed with the next character held pending
    send(8'h0C, 1'b0, 64'h5832_3334_3536_3738, 3'd6, 1'b0, "ff");
    in_valid = 1'b1;
    in_char  = "Z";
    mode     = 1'b0;
    exp_q.push_back('{64'h5A00_0000_0000_0000, 3'd6, 1'b0});
    name_q.push_back("wr_Z");
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      if (cnt == 4) check("clear_partial", asciix8, 64'h5832_3334_0000_0000);
      @(negedge CLK100MHZ);
      cnt++;
    end
    check("clear_busy_cycles", 64'(cnt), 64'd8);
    check("clear_buf", asciix8, 64'h0);
    check("clear_cursor", {61'd0, cursor}, 64'd7);
    @(negedge CLK100MHZ);
    in_valid = 1'b0;

    // Reset in the middle of a clear
    send("Q", 1'b0, 64'h5A51_0000_0000_0000, 3'd5, 1'b0, "wr_Q");
    send(8'h0C, 1'b0, 64'h5A51_0000_0000_0000, 3'd5, 1'b0, "ff2");
    repeat (3) @(negedge CLK100MHZ);
    check("ff2_busy", {63'd0, in_ready}, 64'd0);
    resetn = 1'b0;
    @(negedge CLK100MHZ);
    resetn = 1'b1;
    check("midrst_buf", asciix8, 64'h0);
    check("midrst_cursor", {61'd0, cursor}, 64'd7);
    check("midrst_ready", {63'd0, in_ready}, 64'd1);
    @(negedge CLK100MHZ);
    send(8'h0D, 1'b0, 64'h0, 3'd7, 1'b0, "midrst_cr");
    send(8'h01, 1'b0, 64'h0, 3'd7, 1'b0, "midrst_01");

    // Scroll-in mode: cursor held, oldest digit drops out
    send("M",   1'b0, 64'h4D00_0000_0000_0000, 3'd6, 1'b0, "wr_M");
    send("N",   1'b1, 64'h0000_0000_0000_004E, 3'd6, 1'b0, "scr_N");
    send(8'h08, 1'b1, 64'h0,                   3'd6, 1'b0, "bs1_a");
    send(8'h08, 1'b0, 64'h0,                   3'd7, 1'b0, "bs0_c6b");
    send("H",   1'b1, 64'h0000_0000_0000_0048, 3'd7, 1'b0, "scr_H");
    send("I",   1'b1, 64'h0000_0000_0000_4849, 3'd7, 1'b0, "scr_I");
    send(8'h08, 1'b1, 64'h0000_0000_0000_0048, 3'd7, 1'b0, "bs1_b");

    repeat (3) @(negedge CLK100MHZ);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
